// File: rtl/uart_mem_tx.sv
// UART 8N1 transmitter that streams a block of 32-bit words from a synchronous RAM,
// least-significant byte first, one stop bit per byte.
module uart_mem_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic [ADDR_WIDTH-1:0] wordCount,
    output logic [ADDR_WIDTH-1:0] readAddr,
    input  logic [31:0]           readData,
    output logic                  serialOut,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP,
        FINISH
    } state_t;

    state_t                state;
    logic [CW-1:0]         clk_cnt;
    logic [2:0]            bit_idx;
    logic [1:0]            byte_idx;
    logic [31:0]           word;
    logic [7:0]            shift;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [7:0]            cur_byte;
    logic                  bit_end;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cur_byte = word[7:0];
        case (byte_idx)
            2'd0: cur_byte = word[7:0];
            2'd1: cur_byte = word[15:8];
            2'd2: cur_byte = word[23:16];
            2'd3: cur_byte = word[31:24];
            default: cur_byte = word[7:0];
        endcase
    end

    // Every output is a flop; each state decides the line level for the next cycle,
    // so the line changes exactly on bit boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            readAddr  <= '0;
            remaining <= '0;
            word      <= '0;
            shift     <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            clk_cnt   <= '0;
            serialOut <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (wordCount != '0) begin
                            readAddr  <= startAddr;
                            remaining <= wordCount;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    word      <= readData;
                    byte_idx  <= '0;
                    clk_cnt   <= '0;
                    serialOut <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        serialOut <= cur_byte[0];
                        shift     <= {1'b0, cur_byte[7:1]};
                        state     <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            serialOut <= 1'b1;
                            state     <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            serialOut <= shift[0];
                            shift     <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx != 2'd3) begin
                            // Next byte of the same word follows the stop bit directly.
                            byte_idx  <= byte_idx + 1'b1;
                            serialOut <= 1'b0;
                            state     <= START;
                        end else if (remaining > ADDR_WIDTH'(1)) begin
                            remaining <= remaining - 1'b1;
                            readAddr  <= readAddr + 1'b1;
                            state     <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_tx.sv
// Randomized scoreboard bench for uart_mem_tx: a serial decoder pops expected bytes
// and their expected start-bit cycle from a queue filled by the stimulus tasks.
module tb_uart_mem_tx;

    localparam int CPB = 16;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] startAddr = '0;
    logic [AW-1:0] wordCount = '0;
    logic [AW-1:0] readAddr;
    logic [31:0]   readData;
    logic          serialOut;
    logic          busy;
    logic          done;

    uart_mem_tx #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .startAddr(startAddr),
        .wordCount(wordCount), .readAddr(readAddr), .readData(readData),
        .serialOut(serialOut), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    always @(posedge clk) readData <= mem[readAddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         t;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial decoder: samples mid-bit and checks each byte against the scoreboard.
    initial begin
        int fall;
        logic [7:0] d;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && serialOut === 1'b0) begin
                fall = cyc;
                d = '0;
                repeat (CPB / 2) @(negedge clk);
                chk("start_bit", {31'd0, serialOut}, 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    d[b] = serialOut;
                end
                repeat (CPB) @(negedge clk);
                chk("stop_bit", {31'd0, serialOut}, 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", d);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_value", {24'd0, d}, {24'd0, e.data});
                    chk("byte_time", fall, e.t);
                end
            end
        end
    end

    task automatic run(input logic [AW-1:0] addr, input int cnt, input int ignore_at);
        int c;
        int bound;
        int exp_done;
        logic got;
        logic [AW-1:0] seen[$];
        logic [31:0] w;
        exp_t e;
        @(negedge clk);
        startAddr = addr;
        wordCount = cnt[AW-1:0];
        start = 1'b1;
        c = cyc;
        for (int wi = 0; wi < cnt; wi++) begin
            w = mem[(int'(addr) + wi) % 4096];
            for (int b = 0; b < 4; b++) begin
                e.data = w[8*b +: 8];
                e.t = c + 3 + (4 * wi + b) * 10 * CPB + 2 * wi;
                exp_q.push_back(e);
            end
        end
        exp_done = c + 3 + (4 * cnt - 1) * 10 * CPB + 2 * (cnt - 1) + 10 * CPB;
        @(negedge clk);
        start = 1'b0;
        startAddr = AW'($urandom);
        wordCount = AW'($urandom);
        chk("addr_latency", {20'd0, readAddr}, {20'd0, addr});
        chk("busy_rise", {31'd0, busy}, 32'd1);
        bound = cnt * 40 * CPB + 2 * cnt + 50;
        got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (busy && (seen.size() == 0 || seen[$] !== readAddr)) seen.push_back(readAddr);
            if (k == ignore_at) begin
                start = 1'b1;
                startAddr = AW'($urandom);
                wordCount = AW'($urandom_range(1, 5));
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("done_time", cyc, exp_done);
        chk("addr_steps", seen.size(), cnt);
        for (int i = 0; i < seen.size() && i < cnt; i++)
            chk("addr_seq", {20'd0, seen[i]}, (int'(addr) + i) % 4096);
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[12'h010] = 32'h44332211;

        repeat (5) @(negedge clk);
        chk("rst_serial", {31'd0, serialOut}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {20'd0, readAddr}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        run(12'h010, 1, -1);
        run(12'h100, 3, -1);
        run(12'hFFE, 3, -1);

        // Zero-length request: only a done pulse.
        @(negedge clk);
        startAddr = 12'h055;
        wordCount = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("zero_done_width", {31'd0, done}, 32'd0);
        repeat (CPB * 3) @(negedge clk);
        chk("zero_line_idle", {31'd0, serialOut}, 32'd1);
        chk("zero_busy_after", {31'd0, busy}, 32'd0);

        run(12'h300, 2, CPB * 5);

        // Reset during bit 3 of the second byte, then a clean transfer.
        mon_en = 1'b0;
        @(negedge clk);
        startAddr = 12'h200;
        wordCount = 12'd2;
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 3 + 14 * CPB + CPB / 2) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_serial", {31'd0, serialOut}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_addr", {20'd0, readAddr}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        run(12'h200, 2, -1);

        for (int r = 0; r < 4; r++)
            run(AW'($urandom), $urandom_range(1, 3), (r % 2 == 1) ? $urandom_range(1, 30 * CPB) : -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
